pin_walk_checker: RTL and testbench

- Loopback checker for the CDPGA walking-zero pin test.
- Samples the WIDTH pins driven by the upstream walking-zero generator. That generator drives one pin low, leaves the rest high-Z (read as 1 through pull-ups), and rotates the low pin one position left every 2^21 clk.
- Verifies every step is a clean single zero advancing by +1 modulo WIDTH.
- Counts laps and errors and drives pass/fail status for board LEDs or debug readout.

---
 rtl/pin_walk_pkg.sv | 22 ++
 rtl/pin_sync_settle.sv | 60 ++++++
 rtl/pin_walk_checker.sv | 167 ++++++++++++++++
 tb/tb_pin_walk_checker.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_walk_pkg.sv
// Shared types for the walking-zero pin loopback checker: FSM states, error kinds
// and the position-width helper.
package pin_walk_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } walk_state_t;

  typedef logic [1:0] err_kind_t;

  localparam err_kind_t ERR_NONE    = 2'd0;
  localparam err_kind_t ERR_JUMP    = 2'd1;
  localparam err_kind_t ERR_PATTERN = 2'd2;
  localparam err_kind_t ERR_STUCK   = 2'd3;

  // Width of a pin index; never narrower than one bit.
  function automatic int pos_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/pin_sync_settle.sv
// Synchronises the raw pin bus, waits for SETTLE_CYCLES of stability and emits a
// one-cycle acc_vld with acc_pat whenever a newly accepted pattern differs from the last one.
module pin_sync_settle #(
  parameter int WIDTH         = 21,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] pins_in,
  output logic             acc_vld,
  output logic [WIDTH-1:0] acc_pat
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(SETTLE_CYCLES);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [CNT_W-1:0] stable_cnt;
  logic             accept;

  // Pull-ups read as ones, so the idle bus is all-ones out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= pins_in;
      sync_q2 <= sync_q1;
    end
  end

  // The counter parks one past the accept value so each stable run accepts once.
  assign accept = (stable_cnt == CNT_ACCEPT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      acc_vld    <= 1'b0;
      acc_pat    <= '1;
    end else if (clear) begin
      stable_cnt <= '0;
      acc_vld    <= 1'b0;
      acc_pat    <= '1;
    end else begin
      if (sync_q1 != sync_q2) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_DONE) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
      acc_vld <= accept && (sync_q2 != acc_pat);
      if (accept) begin
        acc_pat <= sync_q2;
      end
    end
  end

endmodule

// File: rtl/pin_walk_checker.sv
// Walking-zero loopback checker: locks on a one-cold pin pattern, verifies +1 steps, counts laps/errors.
// Define PIN_WALK_ERR_CAPTURE_EN to latch the pattern behind the first counted error on first_err_pat.
module pin_walk_checker
  import pin_walk_pkg::*;
#(
  parameter int WIDTH         = 21,
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT_LOG2  = 24,
  parameter int PASS_LAPS     = 2,
  parameter int ERR_CNT_W     = 8,
  localparam int POS_W        = pos_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     pins_in,
  input  logic                 clear,
  output logic                 locked,
  output logic [POS_W-1:0]     cur_pos,
  output logic [7:0]           lap_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 pass,
  output logic                 fail,
  output logic [WIDTH-1:0]     first_err_pat
);

  logic             acc_vld;
  logic [WIDTH-1:0] acc_pat;

  pin_sync_settle #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .pins_in (pins_in),
    .acc_vld (acc_vld),
    .acc_pat (acc_pat)
  );

  walk_state_t             state;
  logic [TIMEOUT_LOG2-1:0] tmo_cnt;
  logic [WIDTH-1:0]        zero_mask;
  logic                    one_cold;
  logic [POS_W-1:0]        acc_pos;
  logic [POS_W-1:0]        nxt_pos;
  logic                    tmo_hit;
  err_kind_t               err_kind;
  logic                    err_evt;
  logic                    lap_inc;

  // Exactly one zero bit; acc_pos is only meaningful when one_cold is set.
  always_comb begin
    zero_mask = ~acc_pat;
    one_cold  = (zero_mask != '0) && ((zero_mask & (zero_mask - WIDTH'(1))) == '0);
    acc_pos   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!acc_pat[i]) begin
        acc_pos = POS_W'(i);
      end
    end
  end

  assign nxt_pos = (cur_pos == POS_W'(WIDTH - 1)) ? '0 : cur_pos + POS_W'(1);
  assign tmo_hit = &tmo_cnt;

  // An accepted pattern preempts the timeout, so a cycle never counts two errors.
  always_comb begin
    err_kind = ERR_NONE;
    lap_inc  = 1'b0;
    if (state == TRACK) begin
      if (acc_vld) begin
        if (!one_cold) begin
          err_kind = ERR_PATTERN;
        end else if (acc_pos != nxt_pos) begin
          err_kind = ERR_JUMP;
        end else begin
          lap_inc = (acc_pos == '0);
        end
      end else if (tmo_hit) begin
        err_kind = ERR_STUCK;
      end
    end
    err_evt = (err_kind != ERR_NONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEARCH;
      locked  <= 1'b0;
      cur_pos <= '0;
      tmo_cnt <= '0;
      lap_cnt <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
      fail    <= 1'b0;
    end else if (clear) begin
      state   <= SEARCH;
      locked  <= 1'b0;
      tmo_cnt <= '0;
      lap_cnt <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (acc_vld && one_cold) begin
            state   <= TRACK;
            locked  <= 1'b1;
            cur_pos <= acc_pos;
            tmo_cnt <= '0;
          end
        end
        TRACK: begin
          if (acc_vld) begin
            tmo_cnt <= '0;
            if (err_kind == ERR_PATTERN) begin
              state  <= SEARCH;
              locked <= 1'b0;
            end else begin
              cur_pos <= acc_pos;
            end
          end else begin
            // Wraps to zero on the stuck error so it re-fires every period.
            tmo_cnt <= tmo_cnt + TIMEOUT_LOG2'(1);
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase

      if (lap_inc && (lap_cnt != 8'hFF)) begin
        lap_cnt <= lap_cnt + 8'd1;
      end
      if (err_evt && !(&err_cnt)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
      if (err_evt) begin
        fail <= 1'b1;
      end
      pass <= !err_evt && (pass || ((lap_cnt >= 8'(PASS_LAPS)) && (err_cnt == '0)));
    end
  end

`ifdef PIN_WALK_ERR_CAPTURE_EN
  logic [WIDTH-1:0] first_err_q;

  // err_cnt is still zero only for the first counted error since reset/clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_q <= '0;
    end else if (clear) begin
      first_err_q <= '0;
    end else if (err_evt && (err_cnt == '0)) begin
      first_err_q <= acc_pat;
    end
  end

  assign first_err_pat = first_err_q;
`else
  assign first_err_pat = '0;
`endif

endmodule

// File: tb/tb_pin_walk_checker.sv
// Directed and randomized bench for pin_walk_checker against a window-based reference model.
module tb_pin_walk_checker;

  localparam int W    = 21;
  localparam int S    = 4;
  localparam int TLOG = 8;
  localparam int PL   = 2;
  localparam int ECW  = 8;
  localparam int NCYC = 16000;

`ifdef PIN_WALK_ERR_CAPTURE_EN
  localparam logic [W-1:0] EXP_STUCK_PAT = 21'h1FFF7F;
`else
  localparam logic [W-1:0] EXP_STUCK_PAT = '0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   pins_in;
  logic           clear;
  logic           locked;
  logic [4:0]     cur_pos;
  logic [7:0]     lap_cnt;
  logic [ECW-1:0] err_cnt;
  logic           pass;
  logic           fail;
  logic [W-1:0]   first_err_pat;

  int checks   = 0;
  int failures = 0;

  pin_walk_checker #(
    .WIDTH         (W),
    .SETTLE_CYCLES (S),
    .TIMEOUT_LOG2  (TLOG),
    .PASS_LAPS     (PL),
    .ERR_CNT_W     (ECW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pins_in       (pins_in),
    .clear         (clear),
    .locked        (locked),
    .cur_pos       (cur_pos),
    .lap_cnt       (lap_cnt),
    .err_cnt       (err_cnt),
    .pass          (pass),
    .fail          (fail),
    .first_err_pat (first_err_pat)
  );

  always #5 clk = ~clk;

  // Reference model state, advanced once per clock edge.
  logic [W-1:0] hist [0:NCYC-1];
  bit           m_locked, m_pass, m_fail, m_arm;
  int           m_pos, m_lap, m_err, m_last;
  logic [W-1:0] m_acc, m_first;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] oc(input int p);
    logic [W-1:0] v;
    v    = '1;
    v[p] = 1'b0;
    return v;
  endfunction

  function automatic logic [W-1:0] hv(input int i);
    return (i < 0) ? '1 : hist[i];
  endfunction

  // A pattern whose run starts at cycle s and lasts S cycles shows on the outputs after edge s+S+3.
  task automatic model_step(input int k);
    int           s, zeros, pos;
    bit           acc, err, stable;
    logic [W-1:0] p;
    acc = 0;
    err = 0;
    s   = k - S - 3;
    p   = hv(s);
    if (p != hv(s - 1)) begin
      stable = 1;
      for (int j = 1; j < S; j++) if (hv(s + j) != p) stable = 0;
      if (stable && (p != m_acc)) begin
        acc   = 1;
        m_acc = p;
      end
    end
    if (acc) begin
      zeros = 0;
      pos   = 0;
      for (int i = 0; i < W; i++) if (!p[i]) begin zeros++; pos = i; end
      if (!m_locked) begin
        if (zeros == 1) begin m_locked = 1; m_pos = pos; m_last = k; end
      end else if (zeros != 1) begin
        err      = 1;
        m_locked = 0;
      end else begin
        if (pos != (m_pos + 1) % W) err = 1;
        else if (pos == 0 && m_lap < 255) m_lap++;
        m_pos  = pos;
        m_last = k;
      end
    end else if (m_locked && (k - m_last) == (1 << TLOG)) begin
      err    = 1;
      m_last = k;
    end
    m_pass = !err && (m_pass || m_arm);
    if (err) begin
      if (m_err == 0) m_first = m_acc;
      if (m_err < (1 << ECW) - 1) m_err++;
      m_fail = 1;
    end
    m_arm = (m_lap >= PL) && (m_err == 0);
  endtask

  task automatic compare_model();
    check("rnd_locked", 32'(locked), 32'(m_locked));
    if (m_locked) check("rnd_cur_pos", 32'(cur_pos), 32'(m_pos));
    check("rnd_lap_cnt", 32'(lap_cnt), 32'(m_lap));
    check("rnd_err_cnt", 32'(err_cnt), 32'(m_err));
    check("rnd_pass", 32'(pass), 32'(m_pass));
    check("rnd_fail", 32'(fail), 32'(m_fail));
`ifdef PIN_WALK_ERR_CAPTURE_EN
    check("rnd_first_err_pat", 32'(first_err_pat), 32'(m_first));
`else
    check("rnd_first_err_pat", 32'(first_err_pat), 32'(0));
`endif
  endtask

  initial begin
    int           g, seg_left, pend_len, nseg, r;
    logic [W-1:0] seg_val, ret_val, flip;

    rst_n   = 1'b0;
    clear   = 1'b0;
    pins_in = '1;
    tick(3);
    check("rst_locked", 32'(locked), 0);
    check("rst_cur_pos", 32'(cur_pos), 0);
    check("rst_lap_cnt", 32'(lap_cnt), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_first_err_pat", 32'(first_err_pat), 0);
    rst_n = 1'b1;
    tick(5);

    // First lock lands exactly SETTLE_CYCLES+3 clocks after the change.
    pins_in = oc(0);
    tick(6);
    check("lock_early", 32'(locked), 0);
    tick(1);
    check("lock_locked", 32'(locked), 1);
    check("lock_cur_pos", 32'(cur_pos), 0);
    check("lock_err_cnt", 32'(err_cnt), 0);
    tick(13);

    for (int lap = 0; lap < 2; lap++) begin
      for (int p = 1; p <= W; p++) begin
        pins_in = oc(p % W);
        tick(20);
      end
    end
    check("walk_lap_cnt", 32'(lap_cnt), 2);
    check("walk_pass", 32'(pass), 1);
    check("walk_fail", 32'(fail), 0);
    check("walk_err_cnt", 32'(err_cnt), 0);

    for (int p = 1; p <= 5; p++) begin
      pins_in = oc(p);
      tick(20);
    end
    check("pre_jump_cur_pos", 32'(cur_pos), 5);
    pins_in = oc(9);
    tick(20);
    check("jump_err_cnt", 32'(err_cnt), 1);
    check("jump_cur_pos", 32'(cur_pos), 9);
    check("jump_locked", 32'(locked), 1);
    check("jump_fail", 32'(fail), 1);
    check("jump_pass", 32'(pass), 0);

    pins_in = oc(3);
    tick(20);
    check("jump2_err_cnt", 32'(err_cnt), 2);
    pins_in = '1;
    tick(20);
    check("open_err_cnt", 32'(err_cnt), 3);
    check("open_locked", 32'(locked), 0);
    pins_in = oc(4);
    tick(20);
    check("relock_locked", 32'(locked), 1);
    check("relock_cur_pos", 32'(cur_pos), 4);
    check("relock_err_cnt", 32'(err_cnt), 3);

    pins_in = '1;
    clear   = 1'b1;
    tick(2);
    clear = 1'b0;
    check("clear_err_cnt", 32'(err_cnt), 0);
    check("clear_locked", 32'(locked), 0);
    check("clear_fail", 32'(fail), 0);
    check("clear_lap_cnt", 32'(lap_cnt), 0);
    check("clear_first_err_pat", 32'(first_err_pat), 0);
    tick(8);

    pins_in = oc(7);
    tick(7);
    check("stuck_lock", 32'(locked), 1);
    tick(255);
    check("stuck_early", 32'(err_cnt), 0);
    tick(1);
    check("stuck_err_cnt", 32'(err_cnt), 1);
    tick(44);
    check("stuck_once", 32'(err_cnt), 1);
    check("stuck_locked", 32'(locked), 1);
    check("stuck_first_err_pat", 32'(first_err_pat), 32'(EXP_STUCK_PAT));

    pins_in = oc(8);
    tick(20);
    check("step8_cur_pos", 32'(cur_pos), 8);
    pins_in = oc(8) & oc(3);
    tick(3);
    pins_in = oc(8);
    tick(20);
    check("glitch_err_cnt", 32'(err_cnt), 1);
    check("glitch_cur_pos", 32'(cur_pos), 8);
    check("glitch_locked", 32'(locked), 1);

    // Clear lands on the same edge that would have counted the jump to 15.
    pins_in = oc(15);
    tick(6);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clrjump_err_cnt", 32'(err_cnt), 0);
    check("clrjump_locked", 32'(locked), 0);
    check("clrjump_fail", 32'(fail), 0);
    tick(10);

    rst_n = 1'b0;
    tick(2);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    tick(10);
    check("postrst_locked", 32'(locked), 1);
    check("postrst_cur_pos", 32'(cur_pos), 15);
    check("postrst_err_cnt", 32'(err_cnt), 0);

    rst_n   = 1'b0;
    pins_in = '1;
    tick(3);
    rst_n = 1'b1;
    tick(10);

    m_locked = 0; m_pass = 0; m_fail = 0; m_arm = 0;
    m_pos = 0; m_lap = 0; m_err = 0; m_last = 0;
    m_acc = '1; m_first = '0;
    g = W - 1; seg_left = 0; pend_len = 0; nseg = 0;
    seg_val = '1; ret_val = '1;

    for (int k = 0; k < NCYC; k++) begin
      model_step(k);
      compare_model();
      if (seg_left == 0) begin
        if (pend_len > 0) begin
          seg_val  = ret_val;
          seg_left = pend_len;
          pend_len = 0;
        end else begin
          r = (nseg < 50) ? 0 : $urandom_range(0, 99);
          nseg++;
          if (r < 60) begin
            g = (g + 1) % W; seg_val = oc(g); seg_left = $urandom_range(6, 25);
          end else if (r < 68) begin
            g = $urandom_range(0, W - 1); seg_val = oc(g); seg_left = $urandom_range(6, 25);
          end else if (r < 74) begin
            seg_val = '1; seg_left = $urandom_range(6, 20);
          end else if (r < 80) begin
            seg_val = oc(g) & oc($urandom_range(0, W - 1)); seg_left = $urandom_range(6, 20);
          end else if (r < 90) begin
            flip = '0;
            flip[$urandom_range(0, W - 1)] = 1'b1;
            ret_val  = oc(g);
            pend_len = $urandom_range(6, 20);
            seg_val  = oc(g) ^ flip;
            seg_left = $urandom_range(1, 3);
          end else if (r < 94) begin
            seg_val = oc(g); seg_left = $urandom_range(260, 300);
          end else begin
            g = (g + 1) % W; seg_val = oc(g); seg_left = $urandom_range(1, 8);
          end
        end
      end
      seg_left--;
      hist[k] = seg_val;
      pins_in = seg_val;
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
